// File: rtl/ysyx_23060187_iter_alu.sv
// ----------------------------------------------------------------------------
// ysyx_23060187_iter_alu
//
// Handshaked ALU for the NPC execute stage. Logic, add/sub, shifts and
// compares finish in one step. Unsigned multiply and divide iterate one bit
// per cycle. Every result is registered and held until the writeback stage
// takes it.
//
// Parameters
//   WIDTH  operand/result width (>= 4, power of two)
//   SHW    shift-amount bits taken from opnum2 (derived from WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   block can accept a request (IDLE only)
//   alu_ctrl   operation code, sampled at accept
//   opnum1     operand A, sampled at accept
//   opnum2     operand B, sampled at accept
//   out_valid  result, zero and cout are valid
//   out_ready  consumer takes the result
//   result     registered result
//   zero       registered (result == 0)
//   cout       carry-out for ADD/SUB, 0 for every other op
// ----------------------------------------------------------------------------
module ysyx_23060187_iter_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] opnum1,
   input  logic [WIDTH-1:0] opnum2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout
);

   // The step counter has to hold the value WIDTH itself.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SLL   = 4'd3;
   localparam logic [3:0] OP_SRL   = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_MULHU = 4'd11;
   localparam logic [3:0] OP_DIVU  = 4'd12;
   localparam logic [3:0] OP_REMU  = 4'd13;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               div_sel_q, div_sel_d;
   logic               hi_sel_q, hi_sel_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               cout_q, cout_d;

   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_sum;
   logic [WIDTH-1:0]   single_res;
   logic               single_cout;
   logic               is_iter;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] step_next;
   logic [WIDTH-1:0]   iter_res;

   // Single-step datapath, evaluated straight from the request inputs so the
   // answer can be registered on the accept edge. Divide by zero is also
   // resolved here because it never enters the iterative loop.
   always_comb begin
      shamt       = opnum2[SHW-1:0];
      add_sum     = {1'b0, opnum1} + {1'b0, opnum2};
      sub_sum     = {1'b0, opnum1} + {1'b0, ~opnum2} + {{WIDTH{1'b0}}, 1'b1};
      single_res  = '0;
      single_cout = 1'b0;
      is_iter     = 1'b0;
      case (alu_ctrl)
         OP_AND:  single_res = opnum1 & opnum2;
         OP_OR:   single_res = opnum1 | opnum2;
         OP_ADD: begin
            single_res  = add_sum[WIDTH-1:0];
            single_cout = add_sum[WIDTH];
         end
         OP_SLL:  single_res = opnum1 << shamt;
         OP_SRL:  single_res = opnum1 >> shamt;
         OP_XOR:  single_res = opnum1 ^ opnum2;
         OP_SUB: begin
            single_res  = sub_sum[WIDTH-1:0];
            single_cout = sub_sum[WIDTH];
         end
         OP_SRA:  single_res = $unsigned($signed(opnum1) >>> shamt);
         OP_SLT:  single_res = WIDTH'($signed(opnum1) < $signed(opnum2));
         OP_SLTU: single_res = WIDTH'(opnum1 < opnum2);
         OP_MUL, OP_MULHU: is_iter = 1'b1;
         OP_DIVU: begin
            if (opnum2 == '0) single_res = '1;
            else              is_iter    = 1'b1;
         end
         OP_REMU: begin
            if (opnum2 == '0) single_res = opnum1;
            else              is_iter    = 1'b1;
         end
         default: single_res = '0;
      endcase
   end

   // One iteration of the multi-cycle ops. The accumulator is {hi, lo}.
   // Multiply: lo starts as the multiplier and is consumed LSB first while
   // the partial product grows into hi; the add's carry shifts in at the top.
   // Divide: lo starts as the dividend and is consumed MSB first, hi is the
   // running remainder, quotient bits shift into lo from the right. Because
   // the remainder is always below the divisor, the sign of the (WIDTH+1)-bit
   // trial subtraction is a clean "fits" test.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, b_q};
      div_ge    = ~div_trial[WIDTH];
      div_next  = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
      step_next = div_sel_q ? div_next : mul_next;
      iter_res  = hi_sel_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
   end

   // Next-state logic. Result, zero and cout only change on entry to DONE,
   // so the consumer sees them frozen for as long as it stalls.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      b_d       = b_q;
      div_sel_d = div_sel_q;
      hi_sel_d  = hi_sel_q;
      result_d  = result_q;
      zero_d    = zero_q;
      cout_d    = cout_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               // Opcodes 10..13: bit 2 picks divide, bit 0 picks the high half.
               div_sel_d = alu_ctrl[2];
               hi_sel_d  = alu_ctrl[0];
               b_d       = opnum2;
               if (is_iter) begin
                  acc_d   = {{WIDTH{1'b0}}, opnum1};
                  cnt_d   = CNT_INIT;
                  state_d = ST_CALC;
               end else begin
                  result_d = single_res;
                  zero_d   = (single_res == '0);
                  cout_d   = single_cout;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_CALC: begin
            acc_d = step_next;
            cnt_d = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
               result_d = iter_res;
               zero_d   = (iter_res == '0);
               cout_d   = 1'b0;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         div_sel_q <= 1'b0;
         hi_sel_q  <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         cout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         div_sel_q <= div_sel_d;
         hi_sel_q  <= hi_sel_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         cout_q    <= cout_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign cout      = cout_q;

endmodule
